// File: rtl/note_seq_pkg.sv
// Shared types and constant tables for the RAM-programmable note sequencer.
package note_seq_pkg;

   // Playback controller states.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2
   } state_t;

   // Song entry layout, LSB first: {end, note, len}.
   localparam int LEN_POS = 0;

   function automatic int note_pos(input int len_w);
      return len_w;
   endfunction

   function automatic int end_pos(input int note_w, input int len_w);
      return note_w + len_w;
   endfunction

   function automatic int entry_w(input int note_w, input int len_w);
      return 1 + note_w + len_w;
   endfunction

   // Attack envelope: 16 steps, values already doubled, saturates on the last one.
   localparam int ENV_IDX_W = 4;
   localparam int ENV_W     = 9;
   localparam logic [ENV_IDX_W-1:0] ENV_LAST = 4'd15;
   localparam logic [ENV_W-1:0] ENV_TABLE [16] = '{
      9'd6,  9'd8,  9'd12, 9'd14, 9'd16, 9'd18, 9'd20, 9'd20,
      9'd20, 9'd22, 9'd24, 9'd24, 9'd26, 9'd30, 9'd30, 9'd30
   };

   // Vibrato: eight-step phase adjust, two's complement, added modulo 2^32.
   localparam int VIB_IDX_W = 3;
   localparam logic [31:0] VIB_TABLE [8] = '{
      32'h0000_0000, 32'hFFFF_F8E5, 32'hFFFF_F506, 32'hFFFF_F8E5,
      32'h0000_0000, 32'h0000_079E, 32'h0000_0B1F, 32'h0000_079E
   };

endpackage

// File: rtl/note_seq_song_ram.sv
// Song storage: one write port, one registered read port. A read and a write of the
// same address on the same edge returns the previous contents.
module note_seq_song_ram #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 12,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read-before-write storage array with registered read data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/note_table.sv
// Note code to 32-bit phase increment. Code 0 is a rest (increment 0); code 1 is C2
// and codes climb in semitones. Octave-7 increments are for a 25 MHz clock and a
// 32-bit accumulator; lower octaves are those values shifted right.
module note_table #(
   parameter int NOTE_W = 6
) (
   input  logic [NOTE_W-1:0] note,
   output logic [31:0]       phase_delta
);

   localparam logic [31:0] OCT7 [12] = '{
      32'd359576, 32'd380957, 32'd403610, 32'd427610, 32'd453037, 32'd479976,
      32'd508517, 32'd538754, 32'd570791, 32'd604731, 32'd640691, 32'd678789
   };

   int unsigned code;
   logic [5:0]  idx;
   logic [2:0]  oct;
   logic [3:0]  semi;

   // Split the code into octave and semitone and scale the octave-7 increment.
   always_comb begin
      code        = 32'(note);
      idx         = 6'd0;
      oct         = 3'd0;
      semi        = 4'd0;
      phase_delta = '0;
      if (code != 0 && code < 64) begin
         idx         = 6'(code - 1);
         oct         = 3'(idx / 6'd12);
         semi        = 4'(idx % 6'd12);
         phase_delta = OCT7[semi] >> (3'd5 - oct);
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Plays {end, note, len} entries from a runtime-writable song RAM into one PWM
// synth channel (top, phase delta, envelope), with attack envelope and vibrato.
// The entry is read on the edge that enters LOAD, so it is waiting in the RAM
// output register when the controller moves to PLAY and latches it.
module note_sequencer #(
   parameter  int CLOCKS_PER_TICK = 415_667,
   parameter  int SONG_DEPTH      = 16,
   parameter  int NOTE_W          = 6,
   parameter  int LEN_W           = 5,
   localparam int AW              = $clog2(SONG_DEPTH),
   localparam int EW              = 1 + NOTE_W + LEN_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [EW-1:0]     i_wr_data,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_loop,
   input  logic              i_vib_en,
   output logic [7:0]        o_top,
   output logic              o_top_valid,
   output logic [31:0]       o_phase_delta,
   output logic [8:0]        o_envelope,
   output logic [NOTE_W-1:0] o_note,
   output logic              o_new_note,
   output logic              o_playing,
   output logic              o_done
);

   import note_seq_pkg::*;

   localparam int CW       = $clog2(CLOCKS_PER_TICK);
   localparam int NOTE_LSB = note_pos(LEN_W);
   localparam int END_BIT  = end_pos(NOTE_W, LEN_W);
   localparam logic [CW-1:0] TICK_LAST  = CW'(CLOCKS_PER_TICK - 1);
   localparam logic [AW-1:0] LAST_INDEX = AW'(SONG_DEPTH - 1);

   state_t                 state, next_state;
   logic [AW-1:0]          index, next_index;
   logic                   done_set;
   logic [CW-1:0]          tick_cnt;
   logic [LEN_W-1:0]       note_ticks, last_tick;
   logic                   cur_end;
   logic [ENV_IDX_W-1:0]   env_idx, play_env_idx;
   logic [VIB_IDX_W-1:0]   vib_idx, play_vib_idx;
   logic                   tick, note_end, enter_play, stay_play;
   logic [NOTE_W-1:0]      play_note;
   logic [31:0]            base_delta, vib_adj;
   logic                   rd_en;
   logic [EW-1:0]          rd_data;
   logic [LEN_W-1:0]       rd_len;
   logic [NOTE_W-1:0]      rd_note;
   logic                   rd_end;

   assign o_top       = 8'hff;
   assign o_top_valid = 1'b1;

   assign rd_len  = rd_data[LEN_POS +: LEN_W];
   assign rd_note = rd_data[NOTE_LSB +: NOTE_W];
   assign rd_end  = rd_data[END_BIT];

   assign tick       = (state == S_PLAY) && (tick_cnt == TICK_LAST);
   assign note_end   = tick && (note_ticks == last_tick);
   assign enter_play = (state == S_LOAD) && (next_state == S_PLAY);
   assign stay_play  = (state == S_PLAY) && (next_state == S_PLAY);
   assign rd_en      = (next_state == S_LOAD);

   note_seq_song_ram #(
      .DEPTH (SONG_DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk     (i_clk),
      .wr_en   (i_wr_en),
      .wr_addr (i_wr_addr),
      .wr_data (i_wr_data),
      .rd_en   (rd_en),
      .rd_addr (next_index),
      .rd_data (rd_data)
   );

   note_table #(
      .NOTE_W (NOTE_W)
   ) u_note_table (
      .note        (play_note),
      .phase_delta (base_delta)
   );

   // Controller next state: stop beats start, start beats note end.
   always_comb begin
      next_state = state;
      next_index = index;
      done_set   = 1'b0;
      if (i_stop) begin
         next_state = S_IDLE;
      end else if (i_start) begin
         next_state = S_LOAD;
         next_index = '0;
      end else begin
         case (state)
            S_IDLE: next_state = S_IDLE;
            S_LOAD: next_state = S_PLAY;
            S_PLAY: begin
               if (note_end) begin
                  if (cur_end || index == LAST_INDEX) begin
                     if (i_loop) begin
                        next_index = '0;
                        next_state = S_LOAD;
                     end else begin
                        next_state = S_IDLE;
                        done_set   = 1'b1;
                     end
                  end else begin
                     next_index = index + 1'b1;
                     next_state = S_LOAD;
                  end
               end
            end
            default: next_state = S_IDLE;
         endcase
      end
   end

   // Note, envelope step and vibrato step that the next PLAY cycle will present.
   always_comb begin
      play_note    = enter_play ? rd_note : o_note;
      play_env_idx = env_idx;
      play_vib_idx = vib_idx;
      if (enter_play) begin
         play_env_idx = '0;
         play_vib_idx = '0;
      end else if (tick) begin
         play_env_idx = (env_idx == ENV_LAST) ? env_idx : env_idx + 1'b1;
         play_vib_idx = vib_idx + 1'b1;
      end
      vib_adj = (i_vib_en && play_note != '0) ? VIB_TABLE[play_vib_idx] : 32'h0;
   end

   // Controller state and song index.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         index <= '0;
      end else begin
         state <= next_state;
         index <= next_index;
      end
   end

   // Per-note timing: tick divider, ticks elapsed, envelope and vibrato steps.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tick_cnt   <= '0;
         note_ticks <= '0;
         last_tick  <= '0;
         cur_end    <= 1'b0;
         env_idx    <= '0;
         vib_idx    <= '0;
      end else begin
         tick_cnt <= (stay_play && !tick) ? tick_cnt + 1'b1 : '0;
         if (enter_play) begin
            note_ticks <= '0;
            last_tick  <= (rd_len == '0) ? '0 : rd_len - 1'b1;
            cur_end    <= rd_end;
         end else if (stay_play && tick) begin
            note_ticks <= note_ticks + 1'b1;
         end
         env_idx <= play_env_idx;
         vib_idx <= play_vib_idx;
      end
   end

   // Registered channel outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_phase_delta <= '0;
         o_envelope    <= '0;
         o_note        <= '0;
         o_new_note    <= 1'b0;
         o_playing     <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         o_new_note <= enter_play;
         o_done     <= done_set;
         o_playing  <= (next_state != S_IDLE);
         case (next_state)
            S_IDLE: begin
               o_phase_delta <= '0;
               o_envelope    <= '0;
               o_note        <= '0;
            end
            S_LOAD: begin
               o_envelope <= '0;
            end
            S_PLAY: begin
               o_note        <= play_note;
               o_phase_delta <= base_delta + vib_adj;
               o_envelope    <= (play_note == '0) ? '0 : ENV_TABLE[play_env_idx];
            end
            default: begin
               o_envelope <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with a four-clock tick. Stimulus tasks push expected
// output snapshots (keyed by cycle) into a queue; a negedge monitor pops and
// compares them and flags any new_note/done pulse nobody expected.
module tb_note_sequencer;

   localparam int CPT    = 4;
   localparam int DEPTH  = 16;
   localparam int NOTE_W = 6;
   localparam int LEN_W  = 5;
   localparam int AW     = 4;
   localparam int EW     = 1 + NOTE_W + LEN_W;

   // Hand-computed phase increments (25 MHz clock, octave-7 value >> 2).
   localparam logic [31:0] PH_C5 = 32'd89894;
   localparam logic [31:0] PH_E5 = 32'd113259;
   localparam logic [31:0] PH_A5 = 32'd151182;
   localparam int C5 = 37;
   localparam int E5 = 41;
   localparam int A5 = 46;

   int env_ref [16] = '{6, 8, 12, 14, 16, 18, 20, 20, 20, 22, 24, 24, 26, 30, 30, 30};
   int vib_ref [8]  = '{0, -'h71B, -'hAFA, -'h71B, 0, 'h79E, 'hB1F, 'h79E};

   logic              clk;
   logic              rst_n;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [EW-1:0]     wr_data;
   logic              start;
   logic              stop;
   logic              loop_en;
   logic              vib_en;
   logic [7:0]        top;
   logic              top_valid;
   logic [31:0]       phase_delta;
   logic [8:0]        envelope;
   logic [NOTE_W-1:0] note;
   logic              new_note;
   logic              playing;
   logic              done;

   typedef struct packed {
      logic [31:0]       cyc;
      logic [7:0]        tag;
      logic [NOTE_W-1:0] note;
      logic [31:0]       phase;
      logic [8:0]        env;
      logic              nn;
      logic              dn;
      logic              pl;
   } exp_t;

   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   note_sequencer #(
      .CLOCKS_PER_TICK (CPT),
      .SONG_DEPTH      (DEPTH),
      .NOTE_W          (NOTE_W),
      .LEN_W           (LEN_W)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_wr_en       (wr_en),
      .i_wr_addr     (wr_addr),
      .i_wr_data     (wr_data),
      .i_start       (start),
      .i_stop        (stop),
      .i_loop        (loop_en),
      .i_vib_en      (vib_en),
      .o_top         (top),
      .o_top_valid   (top_valid),
      .o_phase_delta (phase_delta),
      .o_envelope    (envelope),
      .o_note        (note),
      .o_new_note    (new_note),
      .o_playing     (playing),
      .o_done        (done)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard helpers ----------------
   function automatic exp_t mk(input int c, input int tag, input int nt, input logic [31:0] ph,
                               input int env, input bit nn, input bit dn, input bit pl);
      exp_t r;
      r.cyc   = 32'(c);
      r.tag   = 8'(tag);
      r.note  = NOTE_W'(nt);
      r.phase = ph;
      r.env   = 9'(env);
      r.nn    = nn;
      r.dn    = dn;
      r.pl    = pl;
      return r;
   endfunction

   function automatic void push_exp(input exp_t r);
      int i;
      i = 0;
      while (i < exp_q.size() && exp_q[i].cyc <= r.cyc) i++;
      exp_q.insert(i, r);
   endfunction

   function automatic void exp_nn(input int c, input int tag, input int nt, input logic [31:0] ph);
      push_exp(mk(c, tag, nt, ph, (nt == 0) ? 0 : 6, 1'b1, 1'b0, 1'b1));
   endfunction

   function automatic void exp_play(input int c, input int tag, input int nt, input logic [31:0] ph,
                                    input int env);
      push_exp(mk(c, tag, nt, ph, env, 1'b0, 1'b0, 1'b1));
   endfunction

   function automatic void exp_done(input int c, input int tag);
      push_exp(mk(c, tag, 0, 32'h0, 0, 1'b0, 1'b1, 1'b0));
   endfunction

   function automatic void exp_idle(input int c, input int tag);
      push_exp(mk(c, tag, 0, 32'h0, 0, 1'b0, 1'b0, 1'b0));
   endfunction

   // ---------------- monitor ----------------
   exp_t e;
   logic hit;

   // Compare outputs against the snapshot due this cycle; catch stray pulses.
   always @(negedge clk) begin
      hit = 1'b0;
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missed tag=%0d due cyc=%0d now cyc=%0d", e.tag, e.cyc, cyc);
      end
      if (exp_q.size() > 0 && int'(exp_q[0].cyc) == cyc) begin
         e   = exp_q.pop_front();
         hit = 1'b1;
         checks++;
         if (note !== e.note || phase_delta !== e.phase || envelope !== e.env ||
             new_note !== e.nn || done !== e.dn || playing !== e.pl ||
             top !== 8'hff || top_valid !== 1'b1) begin
            errors++;
            $display("FAIL out tag=%0d cyc=%0d got note=%0d ph=%0h env=%0d nn=%0b dn=%0b pl=%0b top=%0h tv=%0b want note=%0d ph=%0h env=%0d nn=%0b dn=%0b pl=%0b top=ff tv=1",
                     e.tag, cyc, note, phase_delta, envelope, new_note, done, playing, top, top_valid,
                     e.note, e.phase, e.env, e.nn, e.dn, e.pl);
         end
      end
      if (!hit && (new_note === 1'b1 || done === 1'b1)) begin
         checks++;
         errors++;
         $display("FAIL stray_pulse cyc=%0d got nn=%0b dn=%0b want nn=0 dn=0", cyc, new_note, done);
      end
   end

   // ---------------- driver tasks (entered and left on a negedge) ----------------
   task automatic write_entry(input int addr, input bit e_bit, input int nt, input int len);
      wr_en   = 1'b1;
      wr_addr = AW'(addr);
      wr_data = {e_bit, NOTE_W'(nt), LEN_W'(len)};
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start(output int t0);
      t0    = cyc + 2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop(input bit with_start);
      stop  = 1'b1;
      start = with_start;
      @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      exp_idle(cyc + 1, 1);
      exp_idle(cyc + 3, 2);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      start   = 1'b0;
      stop    = 1'b0;
      loop_en = 1'b0;
      vib_en  = 1'b0;
      @(negedge clk);

      // Reset values.
      do_reset();
      wait_drain(20);

      // Three-entry song, no loop: C5 x2, rest x1, E5 x3 with end.
      write_entry(0, 1'b0, C5, 2);
      write_entry(1, 1'b0, 0, 1);
      write_entry(2, 1'b1, E5, 3);
      pulse_start(t0);
      exp_nn(t0, 10, C5, PH_C5);
      exp_play(t0 + 4, 11, C5, PH_C5, 8);
      exp_nn(t0 + 9, 12, 0, 32'h0);
      exp_play(t0 + 11, 13, 0, 32'h0, 0);
      exp_nn(t0 + 14, 14, E5, PH_E5);
      exp_play(t0 + 22, 15, E5, PH_E5, 12);
      exp_done(t0 + 26, 16);
      exp_idle(t0 + 27, 17);
      wait_drain(80);

      // Same song looping, then a plain stop mid-note.
      loop_en = 1'b1;
      pulse_start(t0);
      exp_nn(t0, 20, C5, PH_C5);
      exp_nn(t0 + 9, 21, 0, 32'h0);
      exp_nn(t0 + 14, 22, E5, PH_E5);
      exp_nn(t0 + 27, 23, C5, PH_C5);
      exp_play(t0 + 28, 24, C5, PH_C5, 6);
      exp_nn(t0 + 36, 25, 0, 32'h0);
      exp_idle(t0 + 39, 26);
      wait_until(t0 + 38);
      pulse_stop(1'b0);
      wait_drain(80);

      // Sixteen entries, end flag clear everywhere: looping wraps after entry 15.
      write_entry(0, 1'b0, C5, 1);
      for (int a = 1; a < 15; a++) write_entry(a, 1'b0, 0, 1);
      write_entry(15, 1'b0, A5, 1);
      pulse_start(t0);
      for (int k = 0; k <= 16; k++)
         exp_nn(t0 + 5 * k, 30, (k == 15) ? A5 : ((k % 16 == 0) ? C5 : 0),
                (k == 15) ? PH_A5 : ((k % 16 == 0) ? PH_C5 : 32'h0));
      exp_idle(t0 + 83, 31);
      wait_until(t0 + 82);
      pulse_stop(1'b0);
      wait_drain(120);

      // Same table without loop: ends after entry 15 with done.
      loop_en = 1'b0;
      pulse_start(t0);
      for (int k = 0; k < 16; k++)
         exp_nn(t0 + 5 * k, 32, (k == 15) ? A5 : ((k == 0) ? C5 : 0),
                (k == 15) ? PH_A5 : ((k == 0) ? PH_C5 : 32'h0));
      exp_done(t0 + 79, 33);
      wait_drain(120);

      // Single long A5: envelope per tick, saturating at 30; phase constant.
      write_entry(0, 1'b1, A5, 20);
      pulse_start(t0);
      exp_nn(t0, 40, A5, PH_A5);
      for (int k = 1; k <= 17; k++)
         exp_play(t0 + 4 * k + 1, 41, A5, PH_A5, env_ref[(k > 15) ? 15 : k]);
      exp_done(t0 + 80, 42);
      wait_drain(120);

      // Length 0 behaves as length 1.
      write_entry(0, 1'b0, C5, 0);
      write_entry(1, 1'b1, E5, 1);
      pulse_start(t0);
      exp_nn(t0, 50, C5, PH_C5);
      exp_nn(t0 + 5, 51, E5, PH_E5);
      exp_done(t0 + 9, 52);
      wait_drain(40);

      // Vibrato on A5, then stop and start together mid-note.
      vib_en = 1'b1;
      write_entry(0, 1'b1, A5, 20);
      pulse_start(t0);
      exp_nn(t0, 60, A5, PH_A5);
      for (int k = 1; k <= 9; k++)
         exp_play(t0 + 4 * k + 1, 61, A5, 32'(int'(PH_A5) + vib_ref[k % 8]), env_ref[k]);
      exp_idle(t0 + 43, 62);
      wait_until(t0 + 42);
      pulse_stop(1'b1);
      vib_en = 1'b0;
      repeat (8) @(negedge clk);
      wait_drain(80);

      // Rewrite entry 1 while entry 0 plays: the new entry is what plays.
      write_entry(0, 1'b0, C5, 2);
      write_entry(1, 1'b1, E5, 1);
      pulse_start(t0);
      exp_nn(t0, 70, C5, PH_C5);
      exp_nn(t0 + 9, 71, A5, PH_A5);
      exp_done(t0 + 13, 72);
      wait_until(t0 + 3);
      write_entry(1, 1'b1, A5, 1);
      wait_drain(40);

      // Reset asserted mid-PLAY clears outputs before the next clock edge.
      write_entry(0, 1'b1, A5, 20);
      pulse_start(t0);
      exp_nn(t0, 80, A5, PH_A5);
      wait_until(t0 + 5);
      @(posedge clk);
      #1;
      exp_idle(cyc, 81);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      exp_idle(cyc + 1, 82);
      rst_n = 1'b1;
      wait_drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog: the run must never hang.
   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog cyc=%0d want run complete", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
